// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle MIPS32 control FSM with imem/dmem ready handshakes
// and a memory-timeout watchdog.  Rev 1.0
`default_nettype none

module mc_control_unit #(
  parameter int ALU_FUNC_W  = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opc,
  input  logic [5:0]            func,
  input  logic                  zero,
  input  logic                  imemReady,
  input  logic                  dmemReady,
  output logic                  imemReq,
  output logic                  dmemReq,
  output logic                  irWrite,
  output logic                  pcWrite,
  output logic [1:0]            pcSrc,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  rfWriteEnable,
  output logic                  rfWriteAddrSel,
  output logic [1:0]            rfWriteDataSel,
  output logic                  aluSrc,
  output logic [ALU_FUNC_W-1:0] aluFunc,
  output logic                  bitXtend,
  output logic                  instrRetired,
  output logic                  invOpcode,
  output logic                  memTimeout,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_BEQ  = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW    = 6'h2B;

  localparam bit             WD_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_EN ? MEM_TIMEOUT - 1 : 0);

  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE:
        return (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B})
               ? S_EXEC : S_TRAP;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:  return S_EXEC;
      OP_LW, OP_SW:                      return S_MEM;
      OP_BEQ, OP_BNE:                    return S_BRANCH;
      OP_J:                              return S_JUMP;
      default:                           return S_TRAP;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE) begin
      case (fn)
        6'h22, 6'h23: return 3'd1;
        6'h24:        return 3'd2;
        6'h25:        return 3'd3;
        6'h26:        return 3'd6;
        6'h2A:        return 3'd4;
        6'h2B:        return 3'd7;
        default:      return 3'd0;
      endcase
    end
    case (op)
      OP_SLTI:  return 3'd4;
      OP_SLTIU: return 3'd7;
      OP_ANDI:  return 3'd2;
      OP_ORI:   return 3'd3;
      OP_XORI:  return 3'd6;
      OP_LUI:   return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

  state_t           cur_state;
  state_t           dec_next;
  logic [5:0]       opc_lat;
  logic [5:0]       func_lat;
  logic [CNT_W-1:0] wd_cnt;
  logic             inv_flag;
  logic             to_flag;
  logic             wd_expire;
  logic             is_rtype;
  logic             is_lw;
  logic             is_sw;
  logic             taken;

  assign dec_next  = decode_next(opc, func);
  assign wd_expire = WD_EN && (wd_cnt == WD_LAST);
  assign is_rtype  = (opc_lat == OP_RTYPE);
  assign is_lw     = (opc_lat == OP_LW);
  assign is_sw     = (opc_lat == OP_SW);
  assign taken     = ((opc_lat == OP_BEQ) && zero) || ((opc_lat == OP_BNE) && !zero);

  // Watchdog counts consecutive not-ready cycles; any other cycle clears it,
  // so every entry into FETCH or MEM starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
      opc_lat   <= '0;
      func_lat  <= '0;
      wd_cnt    <= '0;
      inv_flag  <= 1'b0;
      to_flag   <= 1'b0;
    end else begin
      wd_cnt <= '0;
      case (cur_state)
        S_FETCH: begin
          if (imemReady) begin
            cur_state <= S_DECODE;
          end else if (wd_expire) begin
            cur_state <= S_TRAP;
            to_flag   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          opc_lat   <= opc;
          func_lat  <= func;
          cur_state <= dec_next;
          if (dec_next == S_TRAP) inv_flag <= 1'b1;
        end
        S_EXEC: cur_state <= S_WB;
        S_MEM: begin
          if (dmemReady) begin
            cur_state <= is_lw ? S_WB : S_FETCH;
          end else if (wd_expire) begin
            cur_state <= S_TRAP;
            to_flag   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        S_WB, S_BRANCH, S_JUMP: cur_state <= S_FETCH;
        S_TRAP:                 cur_state <= S_TRAP;
        default:                cur_state <= S_TRAP;
      endcase
    end
  end

  // Outputs depend on the state register and latched IR fields; only the
  // ready inputs and, in BRANCH, zero feed through combinationally.
  always_comb begin
    imemReq        = 1'b0;
    dmemReq        = 1'b0;
    irWrite        = 1'b0;
    pcWrite        = 1'b0;
    pcSrc          = 2'd0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    rfWriteEnable  = 1'b0;
    rfWriteAddrSel = 1'b0;
    rfWriteDataSel = 2'd0;
    aluSrc         = 1'b0;
    aluFunc        = '0;
    bitXtend       = 1'b0;
    instrRetired   = 1'b0;
    invOpcode      = 1'b0;
    memTimeout     = 1'b0;
    state          = 3'd0;
    if (rst_n) begin
      state      = cur_state;
      invOpcode  = inv_flag;
      memTimeout = to_flag;
      case (cur_state)
        S_FETCH: begin
          imemReq = 1'b1;
          irWrite = imemReady;
          pcWrite = imemReady;
        end
        S_EXEC: begin
          aluSrc   = !is_rtype;
          aluFunc  = ALU_FUNC_W'(alu_code(opc_lat, func_lat));
          bitXtend = opc_lat inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
        end
        S_MEM: begin
          dmemReq      = 1'b1;
          aluSrc       = 1'b1;
          memRead      = is_lw;
          memWrite     = is_sw;
          instrRetired = dmemReady && is_sw;
        end
        S_WB: begin
          rfWriteEnable  = 1'b1;
          instrRetired   = 1'b1;
          rfWriteAddrSel = is_rtype;
          rfWriteDataSel = is_lw ? 2'd1 : 2'd0;
        end
        S_BRANCH: begin
          aluFunc      = ALU_FUNC_W'(3'd1);
          instrRetired = 1'b1;
          pcWrite      = taken;
          pcSrc        = taken ? 2'd1 : 2'd0;
        end
        S_JUMP: begin
          pcWrite      = 1'b1;
          pcSrc        = 2'd2;
          instrRetired = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
